// File: rtl/spi_multich_rx_if.sv
// Handshake bundle for spi_multich_rx: SPI-side inputs plus the valid/ready frame output.
// The receiver uses the slave modport; the stimulus/consumer side uses master.
interface spi_multich_rx_if #(
    parameter int unsigned pCH     = 8,
    parameter int unsigned pW_DATA = 8
);
    logic                   spi_iclk;
    logic                   spi_enb;
    logic [pCH-1:0]         idata;
    logic [pCH*pW_DATA-1:0] odata;
    logic                   oval;
    logic                   iready;
    logic                   olast;
    logic                   oerr;
    logic                   ooverflow;

    modport slave (
        input  spi_iclk, spi_enb, idata, iready,
        output odata, oval, olast, oerr, ooverflow
    );

    modport master (
        output spi_iclk, spi_enb, idata, iready,
        input  odata, oval, olast, oerr, ooverflow
    );
endinterface

// File: rtl/spi_multich_rx.sv
// Multi-lane SPI-style frame receiver running entirely in the iclk domain.
// Emits one packed word per good frame; pulses oerr on bad length, ooverflow on a dropped frame.
module spi_multich_rx #(
    parameter int unsigned pCH       = 8,
    parameter int unsigned pW_FRAME  = 10,
    parameter int unsigned pW_DATA   = 8,
    parameter int unsigned pLAST_BIT = 9,
    parameter int unsigned pSYNC     = 2
) (
    input logic             iclk,
    input logic             irst,
    spi_multich_rx_if.slave bus
);
    localparam int unsigned      W_CNT     = $clog2(pW_FRAME + 2);
    localparam logic [W_CNT-1:0] CNT_FRAME = W_CNT'(pW_FRAME);
    localparam logic [W_CNT-1:0] CNT_MAX   = W_CNT'(pW_FRAME + 1);

    typedef enum logic {StIdle, StRecv} state_t;

    logic [pSYNC-1:0]       r_sclk_sync;
    logic [pSYNC-1:0]       r_enb_sync;
    logic [pCH-1:0]         r_data_sync [pSYNC];
    logic                   r_sclk_dly;
    logic                   r_enb_dly;
    state_t                 r_state;
    logic [W_CNT-1:0]       r_cnt;
    logic [pW_FRAME-1:0]    r_shift [pCH];
    logic [pCH*pW_DATA-1:0] r_odata;
    logic                   r_oval;
    logic                   r_olast;
    logic                   r_oerr;
    logic                   r_ovf;

    logic           w_sclk_rise;
    logic           w_enb_fall;
    logic           w_enb_rise;
    logic           w_shift_en;
    logic [pCH-1:0] w_data;

    // Data shares the clock's sync depth so each lane bit lines up with its detected edge.
    always_ff @(posedge iclk) begin
        if (irst) begin
            r_sclk_sync <= '0;
            r_enb_sync  <= '1;
            for (int i = 0; i < int'(pSYNC); i++) r_data_sync[i] <= '0;
            r_sclk_dly  <= 1'b0;
            r_enb_dly   <= 1'b1;
        end else begin
            r_sclk_sync    <= {r_sclk_sync[pSYNC-2:0], bus.spi_iclk};
            r_enb_sync     <= {r_enb_sync[pSYNC-2:0], bus.spi_enb};
            r_data_sync[0] <= bus.idata;
            for (int i = 1; i < int'(pSYNC); i++) r_data_sync[i] <= r_data_sync[i-1];
            r_sclk_dly     <= r_sclk_sync[pSYNC-1];
            r_enb_dly      <= r_enb_sync[pSYNC-1];
        end
    end

    assign w_sclk_rise = r_sclk_sync[pSYNC-1] & ~r_sclk_dly;
    assign w_enb_fall  = ~r_enb_sync[pSYNC-1] & r_enb_dly;
    assign w_enb_rise  = r_enb_sync[pSYNC-1] & ~r_enb_dly;
    assign w_data      = r_data_sync[pSYNC-1];
    assign w_shift_en  = (r_state == StRecv) && w_sclk_rise && !w_enb_rise;

    // Shift registers carry no reset; only a complete frame is ever read out of them.
    always_ff @(posedge iclk) begin
        if (w_shift_en) begin
            for (int i = 0; i < int'(pCH); i++) begin
                r_shift[i] <= {r_shift[i][pW_FRAME-2:0], w_data[i]};
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_odata <= '0;
            r_oval  <= 1'b0;
            r_olast <= 1'b0;
            r_oerr  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_oerr <= 1'b0;
            r_ovf  <= 1'b0;
            if (r_oval && bus.iready) r_oval <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_enb_fall) begin
                        r_state <= StRecv;
                        r_cnt   <= '0;
                    end
                end
                StRecv: begin
                    if (w_enb_rise) begin
                        r_state <= StIdle;
                        if (r_cnt == CNT_FRAME) begin
                            // A same-edge accept frees the register for the new frame.
                            if (!r_oval || bus.iready) begin
                                for (int i = 0; i < int'(pCH); i++) begin
                                    r_odata[i*pW_DATA +: pW_DATA] <= r_shift[i][pW_DATA-1:0];
                                end
                                r_olast <= r_shift[0][pLAST_BIT];
                                r_oval  <= 1'b1;
                            end else begin
                                r_ovf <= 1'b1;
                            end
                        end else if (r_cnt != '0) begin
                            r_oerr <= 1'b1;
                        end
                    end else if (w_shift_en && r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.odata     = r_odata;
    assign bus.oval      = r_oval;
    assign bus.olast     = r_olast;
    assign bus.oerr      = r_oerr;
    assign bus.ooverflow = r_ovf;
endmodule
